// File: rtl/wb_stage_regfile_pkg.sv
// Shared definitions for the writeback stage and its register file:
// default widths, register-file geometry, writeback-select encoding and
// the select-priority helper.
package wb_stage_regfile_pkg;

    localparam int unsigned DATA_W_DFLT    = 32;
    localparam int unsigned INSTRET_W_DFLT = 64;
    localparam int unsigned REG_NUM        = 32;
    localparam int unsigned ADDR_W         = 5;

    localparam logic [ADDR_W-1:0] X0 = 5'd0;

    // Writeback source selection
    typedef enum logic [2:0] {
        SEL_LINK  = 3'd0,   // PC+4 for jal/jalr
        SEL_LUI   = 3'd1,   // immediate
        SEL_AUIPC = 3'd2,   // PC+imm
        SEL_LOAD  = 3'd3,   // load data
        SEL_ALU   = 3'd4    // ALU result
    } wb_sel_e;

    // MEM/WB control bundle
    typedef struct packed {
        logic jal;
        logic jalr;
        logic lui;
        logic u_type;
        logic mem_to_reg;
        logic reg_write;
        logic valid;
    } wb_ctrl_t;

    // Fixed-priority source select; overlapping controls resolve silently.
    function automatic wb_sel_e wb_sel_f(input wb_ctrl_t c);
        wb_sel_e sel;
        if (c.jal || c.jalr)   sel = SEL_LINK;
        else if (c.lui)        sel = SEL_LUI;
        else if (c.u_type)     sel = SEL_AUIPC;
        else if (c.mem_to_reg) sel = SEL_LOAD;
        else                   sel = SEL_ALU;
        return sel;
    endfunction

endpackage

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB-to-writeback bus plus the ID read ports and forwarding outputs.
// master: pipeline side (drives MEM/WB fields and read addresses)
// slave : writeback stage (drives read data, wb result, instret)
interface wb_stage_regfile_if
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned INSTRET_W = INSTRET_W_DFLT
);
    logic [DATA_W-1:0]    ALU_result_wb_i;
    logic [DATA_W-1:0]    pc_jump_wb_i;
    logic [DATA_W-1:0]    loaddata_wb_i;
    logic [DATA_W-1:0]    imme_wb_i;
    logic [DATA_W-1:0]    pc_order_wb_i;
    logic [ADDR_W-1:0]    Rd_wb_i;
    logic                 jal_wb_i;
    logic                 jalr_wb_i;
    logic                 lui_wb_i;
    logic                 U_type_wb_i;
    logic                 MemtoReg_wb_i;
    logic                 RegWrite_wb_i;
    logic                 valid_wb_i;
    logic [ADDR_W-1:0]    rs1_addr_i;
    logic [ADDR_W-1:0]    rs2_addr_i;
    logic [DATA_W-1:0]    rs1_data_o;
    logic [DATA_W-1:0]    rs2_data_o;
    logic [DATA_W-1:0]    wb_data_o;
    logic [ADDR_W-1:0]    wb_rd_o;
    logic                 wb_we_o;
    logic [INSTRET_W-1:0] instret_o;

    modport master (
        output ALU_result_wb_i, pc_jump_wb_i, loaddata_wb_i, imme_wb_i,
               pc_order_wb_i, Rd_wb_i, jal_wb_i, jalr_wb_i, lui_wb_i,
               U_type_wb_i, MemtoReg_wb_i, RegWrite_wb_i, valid_wb_i,
               rs1_addr_i, rs2_addr_i,
        input  rs1_data_o, rs2_data_o, wb_data_o, wb_rd_o, wb_we_o, instret_o
    );

    modport slave (
        input  ALU_result_wb_i, pc_jump_wb_i, loaddata_wb_i, imme_wb_i,
               pc_order_wb_i, Rd_wb_i, jal_wb_i, jalr_wb_i, lui_wb_i,
               U_type_wb_i, MemtoReg_wb_i, RegWrite_wb_i, valid_wb_i,
               rs1_addr_i, rs2_addr_i,
        output rs1_data_o, rs2_data_o, wb_data_o, wb_rd_o, wb_we_o, instret_o
    );

endinterface

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// 31-word integer register file (x1..x31), one write port, two
// combinational read ports with x0-as-zero and write-through bypass.
// Ports: clk, rst (async active-low), we_i/waddr_i/wdata_i write port,
//        raddr1_i/raddr2_i read addresses, rdata1_o/rdata2_o read data.
module regfile_2r1w
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    // x0 has no storage; we_i is never asserted for address 0
    logic [DATA_W-1:0] regs_q [1:REG_NUM-1];

    // Storage update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Read port 1: zero, bypass, then array
    always_comb begin
        rdata1_o = '0;
        if (raddr1_i == X0)                        rdata1_o = '0;
        else if (we_i && (raddr1_i == waddr_i))    rdata1_o = wdata_i;
        else                                       rdata1_o = regs_q[raddr1_i];
    end

    // Read port 2: zero, bypass, then array
    always_comb begin
        rdata2_o = '0;
        if (raddr2_i == X0)                        rdata2_o = '0;
        else if (we_i && (raddr2_i == waddr_i))    rdata2_o = wdata_i;
        else                                       rdata2_o = regs_q[raddr2_i];
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// RV32I writeback stage: selects the writeback value, gates the register
// write, hosts the architectural register file and the retired-instruction
// counter.
// Ports: clk, rst (async active-low), bus (slave modport) carrying the
//        MEM/WB fields, ID read ports, wb_data/wb_rd/wb_we forwarding
//        outputs and the registered instret count.
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DFLT,
    parameter int unsigned INSTRET_W = INSTRET_W_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    wb_stage_regfile_if.slave   bus
);

    wb_ctrl_t             ctrl_c;
    wb_sel_e              sel_c;
    logic [DATA_W-1:0]    wb_data_c;
    logic                 wb_we_c;
    logic [INSTRET_W-1:0] instret_q;
    logic [INSTRET_W-1:0] instret_d;

    assign ctrl_c = '{
        jal:        bus.jal_wb_i,
        jalr:       bus.jalr_wb_i,
        lui:        bus.lui_wb_i,
        u_type:     bus.U_type_wb_i,
        mem_to_reg: bus.MemtoReg_wb_i,
        reg_write:  bus.RegWrite_wb_i,
        valid:      bus.valid_wb_i
    };

    assign sel_c = wb_sel_f(ctrl_c);

    // Writeback value mux
    always_comb begin
        wb_data_c = bus.ALU_result_wb_i;
        case (sel_c)
            SEL_LINK:  wb_data_c = bus.pc_order_wb_i;
            SEL_LUI:   wb_data_c = bus.imme_wb_i;
            SEL_AUIPC: wb_data_c = bus.pc_jump_wb_i;
            SEL_LOAD:  wb_data_c = bus.loaddata_wb_i;
            SEL_ALU:   wb_data_c = bus.ALU_result_wb_i;
            default:   wb_data_c = bus.ALU_result_wb_i;
        endcase
    end

    // Bubbles and x0 targets never write
    assign wb_we_c = ctrl_c.reg_write & ctrl_c.valid & (bus.Rd_wb_i != X0);

    // Every valid instruction retires, including stores and branches
    always_comb begin
        instret_d = instret_q;
        if (ctrl_c.valid) instret_d = instret_q + INSTRET_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= '0;
        else      instret_q <= instret_d;
    end

    regfile_2r1w #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_we_c),
        .waddr_i  (bus.Rd_wb_i),
        .wdata_i  (wb_data_c),
        .raddr1_i (bus.rs1_addr_i),
        .raddr2_i (bus.rs2_addr_i),
        .rdata1_o (bus.rs1_data_o),
        .rdata2_o (bus.rs2_data_o)
    );

    assign bus.wb_data_o = wb_data_c;
    assign bus.wb_rd_o   = bus.Rd_wb_i;
    assign bus.wb_we_o   = wb_we_c;
    assign bus.instret_o = instret_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile. A driver applies one WB bundle per
// cycle, computes the expected response from an array/counter model and
// queues it; a monitor pops and compares on the falling edge. A second
// instance with a 4-bit counter exercises counter wrap-around.
module tb_wb_stage_regfile;
    import wb_stage_regfile_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned IW = 64;
    localparam int unsigned SW = 4;
    localparam int unsigned N_RAND = 400;

    typedef struct packed {
        logic [31:0] alu, pcj, ld, imm, pco;
        logic [4:0]  rd, rs1, rs2;
        logic        jal, jalr, lui, ut, m2r, rw, valid, rstv;
    } stim_t;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] wb, r1, r2;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] ins;
        logic [3:0]  ins_s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_stage_regfile_if #(.DATA_W(DW), .INSTRET_W(IW)) bus   ();
    wb_stage_regfile_if #(.DATA_W(DW), .INSTRET_W(SW)) bus_s ();

    wb_stage_regfile #(.DATA_W(DW), .INSTRET_W(IW)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
    wb_stage_regfile #(.DATA_W(DW), .INSTRET_W(SW)) dut_s (
        .clk (clk), .rst (rst), .bus (bus_s)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          step     = 0;
    logic [31:0] m_regs [32];
    logic [63:0] m_ins;
    int unsigned m_ins_s;

    task automatic chk(input string nm, input logic [31:0] id,
                       input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nm, id, got, expv);
        end
    endtask

    // Reference: source priority written from the architectural rules
    function automatic logic [31:0] ref_wb(input stim_t s);
        if (s.jal || s.jalr) return s.pco;
        if (s.lui)           return s.imm;
        if (s.ut)            return s.pcj;
        if (s.m2r)           return s.ld;
        return s.alu;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a, input stim_t s,
                                             input logic [31:0] wb, input logic we);
        if (a == 5'd0)              return 32'd0;
        if (we && (a == s.rd))      return wb;
        return m_regs[a];
    endfunction

    task automatic apply(input stim_t s);
        bus.ALU_result_wb_i = s.alu;  bus_s.ALU_result_wb_i = s.alu;
        bus.pc_jump_wb_i    = s.pcj;  bus_s.pc_jump_wb_i    = s.pcj;
        bus.loaddata_wb_i   = s.ld;   bus_s.loaddata_wb_i   = s.ld;
        bus.imme_wb_i       = s.imm;  bus_s.imme_wb_i       = s.imm;
        bus.pc_order_wb_i   = s.pco;  bus_s.pc_order_wb_i   = s.pco;
        bus.Rd_wb_i         = s.rd;   bus_s.Rd_wb_i         = s.rd;
        bus.jal_wb_i        = s.jal;  bus_s.jal_wb_i        = s.jal;
        bus.jalr_wb_i       = s.jalr; bus_s.jalr_wb_i       = s.jalr;
        bus.lui_wb_i        = s.lui;  bus_s.lui_wb_i        = s.lui;
        bus.U_type_wb_i     = s.ut;   bus_s.U_type_wb_i     = s.ut;
        bus.MemtoReg_wb_i   = s.m2r;  bus_s.MemtoReg_wb_i   = s.m2r;
        bus.RegWrite_wb_i   = s.rw;   bus_s.RegWrite_wb_i   = s.rw;
        bus.valid_wb_i      = s.valid; bus_s.valid_wb_i     = s.valid;
        bus.rs1_addr_i      = s.rs1;  bus_s.rs1_addr_i      = s.rs1;
        bus.rs2_addr_i      = s.rs2;  bus_s.rs2_addr_i      = s.rs2;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rstv = 1'b1;
        return s;
    endfunction

    // One cycle: apply inputs just after the edge, queue expectation, advance model
    task automatic run_cycle(input stim_t s);
        exp_t        e;
        logic [31:0] wb;
        logic        we;
        @(posedge clk);
        #1;
        apply(s);
        rst = s.rstv;
        if (!s.rstv) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_ins   = 64'd0;
            m_ins_s = 0;
        end
        wb = ref_wb(s);
        we = s.rw && s.valid && (s.rd != 5'd0);
        e.id    = 32'(step);
        e.wb    = wb;
        e.we    = we;
        e.rd    = s.rd;
        e.r1    = ref_read(s.rs1, s, wb, we);
        e.r2    = ref_read(s.rs2, s, wb, we);
        e.ins   = m_ins;
        e.ins_s = 4'(m_ins_s);
        exp_q.push_back(e);
        step++;
        if (s.rstv) begin
            if (we) m_regs[s.rd] = wb;
            if (s.valid) begin
                m_ins   = m_ins + 64'd1;
                m_ins_s = (m_ins_s + 1) % 16;
            end
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.alu   = $urandom;
        s.pcj   = $urandom;
        s.ld    = $urandom;
        s.imm   = $urandom;
        s.pco   = $urandom;
        s.rd    = 5'($urandom_range(0, 31));
        s.rs1   = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 31));
        s.rs2   = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom_range(0, 31));
        s.jal   = ($urandom_range(0, 7) == 0);
        s.jalr  = ($urandom_range(0, 7) == 0);
        s.lui   = ($urandom_range(0, 5) == 0);
        s.ut    = ($urandom_range(0, 5) == 0);
        s.m2r   = ($urandom_range(0, 3) == 0);
        s.rw    = ($urandom_range(0, 3) != 0);
        s.valid = ($urandom_range(0, 4) != 0);
        s.rstv  = ($urandom_range(0, 149) != 0);
        return s;
    endfunction

    // Monitor: compare every queued expectation against the DUT mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_data",   e.id, 64'(bus.wb_data_o),    64'(e.wb));
                chk("wb_we",     e.id, 64'(bus.wb_we_o),      64'(e.we));
                chk("wb_rd",     e.id, 64'(bus.wb_rd_o),      64'(e.rd));
                chk("rs1_data",  e.id, 64'(bus.rs1_data_o),   64'(e.r1));
                chk("rs2_data",  e.id, 64'(bus.rs2_data_o),   64'(e.r2));
                chk("instret",   e.id, bus.instret_o,         e.ins);
                chk("instret_w", e.id, 64'(bus_s.instret_o),  64'(e.ins_s));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ins   = 64'd0;
        m_ins_s = 0;
        apply(idle());

        // Reset state, then release
        s = idle(); s.rstv = 1'b0; run_cycle(s);
        run_cycle(idle());

        // Select priority
        s = idle(); s.jal = 1'b1; s.lui = 1'b1; s.m2r = 1'b1; s.pco = 32'h104;
        s.imm = 32'h12345000; s.ld = 32'hAA; s.pcj = 32'h2000; s.alu = 32'h77;
        s.valid = 1'b1; s.rw = 1'b1; s.rd = 5'd1; run_cycle(s);
        s.jal = 1'b0; s.jalr = 1'b1; s.rd = 5'd2; s.rs1 = 5'd1; run_cycle(s);
        s.jalr = 1'b0; s.rd = 5'd3; s.rs2 = 5'd2; run_cycle(s);
        s.lui = 1'b0; s.ut = 1'b1; s.rd = 5'd4; run_cycle(s);
        s.ut = 1'b0; s.rd = 5'd5; run_cycle(s);
        s.m2r = 1'b0; s.rd = 5'd6; s.rs1 = 5'd6; run_cycle(s);

        // x0 protection
        s = idle(); s.rw = 1'b1; s.valid = 1'b1; s.rd = 5'd0; s.alu = 32'hFFFF_FFFF;
        run_cycle(s);
        s = idle(); run_cycle(s);

        // Dual-port bypass then array read
        s = idle(); s.rw = 1'b1; s.valid = 1'b1; s.rd = 5'd7; s.alu = 32'h55;
        s.rs1 = 5'd7; s.rs2 = 5'd7; run_cycle(s);
        s.rw = 1'b0; s.alu = 32'h0; run_cycle(s);

        // Bubble vs store
        s = idle(); s.rw = 1'b1; s.valid = 1'b1; s.rd = 5'd3; s.alu = 32'h33; run_cycle(s);
        s = idle(); s.rw = 1'b1; s.valid = 1'b0; s.rd = 5'd3; s.alu = 32'h999;
        s.rs1 = 5'd3; run_cycle(s);
        s = idle(); s.valid = 1'b1; s.rs1 = 5'd3; run_cycle(s);
        s = idle(); s.rs1 = 5'd3; run_cycle(s);

        // Mid-run async reset; in-flight write to x9 is lost
        s = idle(); s.rw = 1'b1; s.valid = 1'b1; s.rd = 5'd5; s.alu = 32'hDEAD_BEEF;
        run_cycle(s);
        s = idle(); s.rs1 = 5'd5; run_cycle(s);
        s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd9; s.rw = 1'b1; s.valid = 1'b1;
        s.rd = 5'd9; s.alu = 32'h99; s.rstv = 1'b0; run_cycle(s);
        s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd9; s.rw = 1'b1; s.valid = 1'b1;
        s.rd = 5'd10; s.alu = 32'h1234; run_cycle(s);
        s = idle(); s.rs1 = 5'd10; s.rs2 = 5'd9; run_cycle(s);

        // Random traffic; the 4-bit instance wraps many times
        for (int n = 0; n < int'(N_RAND); n++) run_cycle(rand_stim());

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(step), 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
